// File: rtl/fix_session_tx.sv
// fix_session_tx: serializes FIX.4.2 admin messages (Logout/ResendRequest/Logon/Heartbeat), one byte per cycle.
// Build option FIX_TX_CHECKSUM_EN: when defined the CheckSum field is the true sum, otherwise it is sent as 000.
module fix_session_tx #(
  parameter int unsigned ID_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                send_logon_i,
  input  logic                send_heartbeat_i,
  input  logic                send_logout_i,
  input  logic                resend_req_i,
  input  logic [23:0]         begin_seq_i,
  input  logic [8*ID_LEN-1:0] sender_id_i,
  input  logic [8*ID_LEN-1:0] target_id_i,
  input  logic                set_seq_i,
  input  logic [23:0]         seq_val_i,
  output logic [7:0]          data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                sop_o,
  output logic                eop_o,
  output logic                busy_o,
  output logic                msg_done_o,
  output logic [23:0]         seq_o
);
  localparam int unsigned HDR_LEN    = 16;
  localparam int unsigned COMMON_LEN = 23 + 2 * ID_LEN;
  localparam int unsigned TRL_LEN    = 7;
  localparam int unsigned IDX_W      = 10;
  localparam logic [7:0]  SOH        = 8'h01;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_TRL} state_t;
  typedef enum logic [1:0] {M_HEARTBEAT, M_LOGON, M_RESEND, M_LOGOUT} msg_t;

  function automatic int unsigned body_len(input msg_t mt);
    case (mt)
      M_LOGON:  return COMMON_LEN + 13;
      M_RESEND: return COMMON_LEN + 14;
      default:  return COMMON_LEN;
    endcase
  endfunction

  function automatic logic [7:0] type_char(input msg_t mt);
    case (mt)
      M_LOGON:  return "A";
      M_RESEND: return "2";
      M_LOGOUT: return "5";
      default:  return "0";
    endcase
  endfunction

  function automatic logic [23:0] dec3(input int unsigned v);
    int unsigned r;
    r = v % 1000;
    return {4'h3, 4'(r / 100), 4'h3, 4'((r / 10) % 10), 4'h3, 4'(r % 10)};
  endfunction

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    // 999999 rolls over to 000001; zero is never a valid MsgSeqNum
    if (carry) r = 24'h000001;
    return r;
  endfunction

  state_t           state_q, state_d;
  msg_t             mtype_q, mtype_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       pend_q, pend_d;
  logic [23:0]      bseq_q, bseq_d;
  logic [23:0]      mbseq_q, mbseq_d;
  logic [23:0]      seq_q, seq_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             done_q, done_d;

  logic [3:0]       req;
  logic [3:0]       win_mask;
  msg_t             win_type;
  logic             load;
  logic             fin;
  int unsigned      n;
  int unsigned      blen;
  logic [7:0]       nbyte;
  logic [7:0]       cs_val;

  assign req = {send_logout_i, resend_req_i, send_logon_i, send_heartbeat_i};

  always_comb begin
    win_type = M_HEARTBEAT;
    win_mask = 4'b0001;
    if (pend_q[3]) begin
      win_type = M_LOGOUT;
      win_mask = 4'b1000;
    end else if (pend_q[2]) begin
      win_type = M_RESEND;
      win_mask = 4'b0100;
    end else if (pend_q[1]) begin
      win_type = M_LOGON;
      win_mask = 4'b0010;
    end
  end

  // Control: n is the index of the byte being loaded into the output register this cycle
  always_comb begin
    state_d = state_q;
    mtype_d = mtype_q;
    idx_d   = idx_q;
    pend_d  = pend_q | req;
    bseq_d  = resend_req_i ? begin_seq_i : bseq_q;
    mbseq_d = mbseq_q;
    seq_d   = seq_q;
    done_d  = 1'b0;
    load    = 1'b0;
    fin     = 1'b0;
    n       = 0;
    if (state_q == S_IDLE) begin
      if (set_seq_i) seq_d = seq_val_i;
      if (|pend_q) begin
        load    = 1'b1;
        mtype_d = win_type;
        mbseq_d = bseq_q;
        pend_d  = (pend_q & ~win_mask) | req;
      end
    end else if (valid_q && ready_i) begin
      if (eop_q) begin
        fin     = 1'b1;
        state_d = S_IDLE;
        done_d  = 1'b1;
        seq_d   = bcd_inc(seq_q);
      end else begin
        load = 1'b1;
        n    = 32'(idx_q) + 1;
      end
    end
    blen = body_len(mtype_d);
    if (load) begin
      idx_d = IDX_W'(n);
      if (n < HDR_LEN)             state_d = S_HDR;
      else if (n < HDR_LEN + blen) state_d = S_BODY;
      else                         state_d = S_TRL;
    end
  end

  always_comb begin
    int unsigned b;
    int unsigned k;
    logic [23:0] lenasc;
    logic [23:0] csasc;
    nbyte  = 8'h00;
    b      = 0;
    k      = 0;
    lenasc = dec3(blen);
    csasc  = dec3(32'(cs_val));
    if (n < HDR_LEN) begin
      case (n)
        0:       nbyte = "8";
        1:       nbyte = "=";
        2:       nbyte = "F";
        3:       nbyte = "I";
        4:       nbyte = "X";
        5:       nbyte = ".";
        6:       nbyte = "4";
        7:       nbyte = ".";
        8:       nbyte = "2";
        10:      nbyte = "9";
        11:      nbyte = "=";
        12:      nbyte = lenasc[23:16];
        13:      nbyte = lenasc[15:8];
        14:      nbyte = lenasc[7:0];
        default: nbyte = SOH;
      endcase
    end else if (n < HDR_LEN + blen) begin
      b = n - HDR_LEN;
      if (b < 5) begin
        case (b)
          0:       nbyte = "3";
          1:       nbyte = "5";
          2:       nbyte = "=";
          3:       nbyte = type_char(mtype_d);
          default: nbyte = SOH;
        endcase
      end else if (b < 15) begin
        case (b)
          5:                      nbyte = "3";
          6:                      nbyte = "4";
          7:                      nbyte = "=";
          8, 9, 10, 11, 12, 13:   nbyte = {4'h3, seq_q[4*(13-b) +: 4]};
          default:                nbyte = SOH;
        endcase
      end else if (b < 19 + ID_LEN) begin
        k = b - 15;
        if (k == 0)               nbyte = "4";
        else if (k == 1)          nbyte = "9";
        else if (k == 2)          nbyte = "=";
        else if (k < 3 + ID_LEN)  nbyte = sender_id_i[8*(ID_LEN+2-k) +: 8];
        else                      nbyte = SOH;
      end else if (b < COMMON_LEN) begin
        k = b - (19 + ID_LEN);
        if (k == 0)               nbyte = "5";
        else if (k == 1)          nbyte = "6";
        else if (k == 2)          nbyte = "=";
        else if (k < 3 + ID_LEN)  nbyte = target_id_i[8*(ID_LEN+2-k) +: 8];
        else                      nbyte = SOH;
      end else begin
        k = b - COMMON_LEN;
        if (mtype_d == M_LOGON) begin
          case (k)
            0:       nbyte = "9";
            1:       nbyte = "8";
            2:       nbyte = "=";
            3:       nbyte = "0";
            5:       nbyte = "1";
            6:       nbyte = "0";
            7:       nbyte = "8";
            8:       nbyte = "=";
            9:       nbyte = "0";
            10:      nbyte = "3";
            11:      nbyte = "0";
            default: nbyte = SOH;
          endcase
        end else begin
          case (k)
            0:                 nbyte = "7";
            1:                 nbyte = "=";
            2, 3, 4, 5, 6, 7:  nbyte = {4'h3, mbseq_q[4*(7-k) +: 4]};
            9:                 nbyte = "1";
            10:                nbyte = "6";
            11:                nbyte = "=";
            12:                nbyte = "0";
            default:           nbyte = SOH;
          endcase
        end
      end
    end else begin
      k = n - HDR_LEN - blen;
      case (k)
        0:       nbyte = "1";
        1:       nbyte = "0";
        2:       nbyte = "=";
        3:       nbyte = csasc[23:16];
        4:       nbyte = csasc[15:8];
        5:       nbyte = csasc[7:0];
        default: nbyte = SOH;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (fin) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end else if (load) begin
      data_d  = nbyte;
      valid_d = 1'b1;
      sop_d   = (n == 0);
      eop_d   = (n == HDR_LEN + blen + TRL_LEN - 1);
    end
  end

`ifdef FIX_TX_CHECKSUM_EN
  logic [7:0] cs_q, cs_d;

  // Trailer digits are generated from cs_q, which by then holds every byte before "10="
  always_comb begin
    cs_d = cs_q;
    if (load) begin
      if (n == 0)                  cs_d = nbyte;
      else if (n < HDR_LEN + blen) cs_d = cs_q + nbyte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cs_q <= '0;
    else      cs_q <= cs_d;
  end

  assign cs_val = cs_q;
`else
  assign cs_val = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mtype_q <= M_HEARTBEAT;
      idx_q   <= '0;
      pend_q  <= '0;
      bseq_q  <= '0;
      mbseq_q <= '0;
      seq_q   <= 24'h000001;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mtype_q <= mtype_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      bseq_q  <= bseq_d;
      mbseq_q <= mbseq_d;
      seq_q   <= seq_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      done_q  <= done_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign sop_o      = sop_q;
  assign eop_o      = eop_q;
  assign busy_o     = (state_q != S_IDLE);
  assign msg_done_o = done_q;
  assign seq_o      = seq_q;

endmodule
